// File: rtl/id_ex_hazard_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_hazard_if
//  Purpose  : Bundles the decode-side inputs and the EX-side outputs of the
//             ID/EX hazard stage.
//  Modports : master - decode/control logic (drives decode fields, hold and
//                      flush; observes the registered EX fields, stall and
//                      counter)
//             slave  - the ID/EX stage itself
//  Ports    : holdIn, flushIn, pcIn, readData1In, readData2In, signExtendIn,
//             rsIn, rtIn, rdIn, WBIn, MEMIn, EXIn  (decode -> stage)
//             pcOut, readData1Out, readData2Out, signExtendOut, rsOut,
//             rtOut, rdOut, WBOut, MEMOut, regDstOut, ALUOpOut, ALUSrcOut,
//             validOut, stallOut, stallCount       (stage -> EX / hazard)
//  Revision : 1.0  initial release
// ============================================================================
interface id_ex_hazard_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2,
   parameter int MEM_W  = 3,
   parameter int CNT_W  = 16
);
   logic              holdIn;
   logic              flushIn;
   logic [DATA_W-1:0] pcIn;
   logic [DATA_W-1:0] readData1In;
   logic [DATA_W-1:0] readData2In;
   logic [DATA_W-1:0] signExtendIn;
   logic [REG_W-1:0]  rsIn;
   logic [REG_W-1:0]  rtIn;
   logic [REG_W-1:0]  rdIn;
   logic [WB_W-1:0]   WBIn;
   logic [MEM_W-1:0]  MEMIn;
   logic [3:0]        EXIn;

   logic [DATA_W-1:0] pcOut;
   logic [DATA_W-1:0] readData1Out;
   logic [DATA_W-1:0] readData2Out;
   logic [DATA_W-1:0] signExtendOut;
   logic [REG_W-1:0]  rsOut;
   logic [REG_W-1:0]  rtOut;
   logic [REG_W-1:0]  rdOut;
   logic [WB_W-1:0]   WBOut;
   logic [MEM_W-1:0]  MEMOut;
   logic              regDstOut;
   logic [1:0]        ALUOpOut;
   logic              ALUSrcOut;
   logic              validOut;
   logic              stallOut;
   logic [CNT_W-1:0]  stallCount;

   modport master (
      output holdIn, flushIn, pcIn, readData1In, readData2In, signExtendIn,
             rsIn, rtIn, rdIn, WBIn, MEMIn, EXIn,
      input  pcOut, readData1Out, readData2Out, signExtendOut, rsOut, rtOut,
             rdOut, WBOut, MEMOut, regDstOut, ALUOpOut, ALUSrcOut, validOut,
             stallOut, stallCount
   );

   modport slave (
      input  holdIn, flushIn, pcIn, readData1In, readData2In, signExtendIn,
             rsIn, rtIn, rdIn, WBIn, MEMIn, EXIn,
      output pcOut, readData1Out, readData2Out, signExtendOut, rsOut, rtOut,
             rdOut, WBOut, MEMOut, regDstOut, ALUOpOut, ALUSrcOut, validOut,
             stallOut, stallCount
   );
endinterface
`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_hazard_stage
//  Purpose  : ID/EX pipeline register with load-use hazard detection and
//             automatic bubble insertion, branch flush, hold (freeze), valid
//             tracking and a saturating bubble counter. Captures on the
//             falling edge of clk like every pipeline register in the path.
//  Ports    : clk   - pipeline clock (falling-edge capture)
//             reset - asynchronous, active-low reset
//             bus   - id_ex_hazard_if.slave (decode inputs, EX outputs,
//                     stall request and bubble counter)
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_hazard_stage #(
   parameter int DATA_W      = 32,
   parameter int REG_W       = 5,
   parameter int WB_W        = 2,
   parameter int MEM_W       = 3,
   parameter int MEMREAD_BIT = 1,
   parameter int CNT_W       = 16
) (
   input  wire logic      clk,
   input  wire logic      reset,
   id_ex_hazard_if.slave  bus
);
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   logic [DATA_W-1:0] r_pc, r_rd1, r_rd2, r_se;
   logic [REG_W-1:0]  r_rs, r_rt, r_rd;
   logic [WB_W-1:0]   r_wb;
   logic [MEM_W-1:0]  r_mem;
   logic              r_regdst;
   logic [1:0]        r_aluop;
   logic              r_alusrc;
   logic              r_valid;
   logic [CNT_W-1:0]  r_cnt;

   logic w_hazard;
   logic w_stall;
   logic w_bubble;

   // A load sitting in EX whose destination (rt) is read by the instruction
   // in decode. $zero is never a real dependency. Bubbles clear MEMOut and
   // validOut, so a single bubble always resolves the hazard.
   assign w_hazard = r_valid & r_mem[MEMREAD_BIT] & (r_rt != '0) &
                     ((r_rt == bus.rsIn) | (r_rt == bus.rtIn));
   // Flush squashes the dependent instruction anyway; hold freezes the
   // stage, so the hazard is simply re-evaluated once hold drops.
   assign w_stall  = w_hazard & ~bus.flushIn & ~bus.holdIn;
   assign w_bubble = bus.flushIn | w_stall;

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         r_pc     <= '0;
         r_rd1    <= '0;
         r_rd2    <= '0;
         r_se     <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_rd     <= '0;
         r_wb     <= '0;
         r_mem    <= '0;
         r_regdst <= 1'b0;
         r_aluop  <= 2'b00;
         r_alusrc <= 1'b0;
         r_valid  <= 1'b0;
         r_cnt    <= '0;
      end else if (!bus.holdIn) begin
         // Data and specifier fields are captured on bubbles too; they are
         // don't-care there and this keeps their enables trivial.
         r_pc  <= bus.pcIn;
         r_rd1 <= bus.readData1In;
         r_rd2 <= bus.readData2In;
         r_se  <= bus.signExtendIn;
         r_rs  <= bus.rsIn;
         r_rt  <= bus.rtIn;
         r_rd  <= bus.rdIn;
         if (w_bubble) begin
            r_wb     <= '0;
            r_mem    <= '0;
            r_regdst <= 1'b0;
            r_aluop  <= 2'b00;
            r_alusrc <= 1'b0;
            r_valid  <= 1'b0;
            if (w_stall && (r_cnt != c_CNT_MAX)) begin
               r_cnt <= r_cnt + c_CNT_ONE;
            end
         end else begin
            r_wb     <= bus.WBIn;
            r_mem    <= bus.MEMIn;
            r_regdst <= bus.EXIn[3];
            r_aluop  <= bus.EXIn[2:1];
            r_alusrc <= bus.EXIn[0];
            r_valid  <= 1'b1;
         end
      end
   end

   assign bus.pcOut         = r_pc;
   assign bus.readData1Out  = r_rd1;
   assign bus.readData2Out  = r_rd2;
   assign bus.signExtendOut = r_se;
   assign bus.rsOut         = r_rs;
   assign bus.rtOut         = r_rt;
   assign bus.rdOut         = r_rd;
   assign bus.WBOut         = r_wb;
   assign bus.MEMOut        = r_mem;
   assign bus.regDstOut     = r_regdst;
   assign bus.ALUOpOut      = r_aluop;
   assign bus.ALUSrcOut     = r_alusrc;
   assign bus.validOut      = r_valid;
   assign bus.stallOut      = w_stall;
   assign bus.stallCount    = r_cnt;
endmodule
`default_nettype wire
